// File: rtl/servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// servo_pulse_decoder
//
// Decodes an RC-servo style PWM input into an 8-bit position code.
// The high time w of each pulse (in clk cycles) maps to
//   code = floor(max(0, w - OFFSET_CYCLES) / STEP_CYCLES), saturating at 255.
// No divider is used. An offset counter first consumes OFFSET_CYCLES of high
// time. After that, a prescaler bumps the code once every STEP_CYCLES clocks.
//
// Ports
//   clk        single clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        decoder enable (0 forces ARM, freezes outputs except pos_valid)
//   pwm_in     asynchronous servo pulse input
//   pos_out    last decoded position code
//   pos_valid  one-cycle strobe: pos_out has just been loaded
//   pulse_err  last pulse exceeded MAX_PULSE_CYCLES (sticky until next report)
//   lost       no rising edge within TIMEOUT_CYCLES
//   dbg_state  current FSM state (ARM=0, WAIT_RISE=1, MEASURE=2, REPORT=3)
//
// Handshake: pos_valid is a valid-only strobe with no ready. It is high for
// exactly one cycle per accepted pulse. pos_out changes only in that same
// cycle and then holds until the next strobe, so a consumer may sample
// pos_out in the pos_valid cycle or at any later time.
// -----------------------------------------------------------------------------
module servo_pulse_decoder #(
    parameter int OFFSET_CYCLES    = 10000,
    parameter int STEP_CYCLES      = 39,
    parameter int MAX_PULSE_CYCLES = 25000,
    parameter int TIMEOUT_CYCLES   = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pwm_in,
    output logic [7:0] pos_out,
    output logic       pos_valid,
    output logic       pulse_err,
    output logic       lost,
    output logic [1:0] dbg_state
);

    // Every counter can hold its parameter + 1 without wrapping.
    localparam int OFF_W  = $clog2(OFFSET_CYCLES + 2);
    localparam int STEP_W = $clog2(STEP_CYCLES + 2);
    localparam int W_W    = $clog2(MAX_PULSE_CYCLES + 2);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [OFF_W-1:0]  OFF_MAX   = OFF_W'(OFFSET_CYCLES);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [W_W-1:0]    W_MAX     = W_W'(MAX_PULSE_CYCLES);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        REPORT    = 2'd3
    } state_t;

    state_t state;

    // Synchroniser (s1 -> s) plus the edge-detect flop s_d.
    logic s1;
    logic s;
    logic s_d;
    logic rise;

    // sync_ok[1] goes high once the synchroniser holds real samples of
    // pwm_in. Until then s reads as the reset value 0. ARM would otherwise
    // take that value for a genuine low and then accept a pulse that was
    // already high when reset was released.
    logic [1:0] sync_ok;

    logic [OFF_W-1:0]  off_cnt;
    logic [STEP_W-1:0] pre_cnt;
    logic [7:0]        code;
    logic [W_W-1:0]    w_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic              start;
    logic [OFF_W-1:0]  m_off;
    logic [STEP_W-1:0] m_pre;
    logic [7:0]        m_code;
    logic [OFF_W-1:0]  off_nxt;
    logic [STEP_W-1:0] pre_nxt;
    logic [7:0]        code_nxt;

    assign rise      = s & ~s_d;
    assign start     = (state == WAIT_RISE) && rise;
    assign dbg_state = state;

    // Advance the width logic by one high clock. On the rising-edge cycle
    // the counters start from zero, so that cycle counts as the first high
    // clock.
    always_comb begin
        m_off    = start ? '0 : off_cnt;
        m_pre    = start ? '0 : pre_cnt;
        m_code   = start ? '0 : code;
        off_nxt  = m_off;
        pre_nxt  = m_pre;
        code_nxt = m_code;
        if (m_off != OFF_MAX) begin
            off_nxt = m_off + 1'b1;
        end else if (m_pre == STEP_LAST) begin
            pre_nxt = '0;
            if (m_code != 8'hFF) begin
                code_nxt = m_code + 8'd1;
            end
        end else begin
            pre_nxt = m_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARM;
            s1        <= 1'b0;
            s         <= 1'b0;
            s_d       <= 1'b0;
            sync_ok   <= 2'b00;
            off_cnt   <= '0;
            pre_cnt   <= '0;
            code      <= '0;
            w_cnt     <= '0;
            to_cnt    <= '0;
            pos_out   <= '0;
            pos_valid <= 1'b0;
            pulse_err <= 1'b0;
            lost      <= 1'b0;
        end else begin
            s1        <= pwm_in;
            s         <= s1;
            s_d       <= s;
            sync_ok   <= {sync_ok[0], 1'b1};
            pos_valid <= 1'b0;

            // Signal-lost watchdog. The rise branch comes first, so a rising
            // edge that arrives on the terminal count keeps lost low.
            if (!ena) begin
                to_cnt <= '0;
            end else if (rise) begin
                to_cnt <= '0;
                lost   <= 1'b0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) begin
                    lost <= 1'b1;
                end
            end

            if (!ena) begin
                state <= ARM;
            end else begin
                case (state)
                    ARM: begin
                        if (sync_ok[1] && !s) begin
                            state <= WAIT_RISE;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            off_cnt <= off_nxt;
                            pre_cnt <= pre_nxt;
                            code    <= code_nxt;
                            w_cnt   <= W_W'(1);
                            state   <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (s) begin
                            if (w_cnt == W_MAX) begin
                                // This clock would be high clock MAX+1.
                                pulse_err <= 1'b1;
                                state     <= ARM;
                            end else begin
                                w_cnt   <= w_cnt + 1'b1;
                                off_cnt <= off_nxt;
                                pre_cnt <= pre_nxt;
                                code    <= code_nxt;
                            end
                        end else begin
                            // MEASURE is entered with s high, so the first
                            // low seen here is the falling edge.
                            state <= REPORT;
                        end
                    end
                    REPORT: begin
                        pos_out   <= code;
                        pos_valid <= 1'b1;
                        pulse_err <= 1'b0;
                        state     <= WAIT_RISE;
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_servo_pulse_decoder
//
// Directed bench for servo_pulse_decoder, run with scaled-down parameters:
// OFFSET=100, STEP=2, MAX=700, TIMEOUT=3000.
// Pulse widths scale accordingly:
//   356 -> 128, 100 -> 0, 50 -> 0, 650 -> 255 (saturated), 102 -> 1,
//   101 -> 0, 700 -> 255 (largest legal width), 800 -> error.
// Edge numbers are counted from the clock edge after pwm_in rises.
// The synchroniser adds two edges, so the rising edge is seen at edge 3.
// -----------------------------------------------------------------------------
module tb_servo_pulse_decoder;

    localparam int OFF  = 100;
    localparam int STEP = 2;
    localparam int MAXP = 700;
    localparam int TOUT = 3000;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       pwm_in;
    logic [7:0] pos_out;
    logic       pos_valid;
    logic       pulse_err;
    logic       lost;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    servo_pulse_decoder #(
        .OFFSET_CYCLES   (OFF),
        .STEP_CYCLES     (STEP),
        .MAX_PULSE_CYCLES(MAXP),
        .TIMEOUT_CYCLES  (TOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .pwm_in   (pwm_in),
        .pos_out  (pos_out),
        .pos_valid(pos_valid),
        .pulse_err(pulse_err),
        .lost     (lost),
        .dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // scoreboard check
    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver: pwm_in high for 'high' edges, then low for 'low' edges.
    // Outputs are sampled 1 time unit after each rising edge. Edge numbers
    // are relative to the pulse start (vedge is relative to the fall).
    task automatic run_pulse(input int high, input int low,
                             output int nvalid, output int vedge, output int vcode,
                             output int err_edge, output int lost_on, output int lost_off);
        nvalid   = 0;
        vedge    = 0;
        vcode    = -1;
        err_edge = 0;
        lost_on  = 0;
        lost_off = 0;
        pwm_in   = 1'b1;
        for (int e = 1; e <= high + low; e++) begin
            @(posedge clk);
            #1;
            if (e == high) pwm_in = 1'b0;
            if (pos_valid) begin
                nvalid++;
                if (vedge == 0) begin
                    vedge = e - high;
                    vcode = int'(pos_out);
                end
            end
            if (pulse_err && err_edge == 0) err_edge = e;
            if (lost && lost_on == 0) lost_on = e;
            if (!lost && lost_off == 0) lost_off = e;
        end
    endtask

    int nv, ve, vc, ee, lon, loff;

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check("rst_pos_out", int'(pos_out), 0);
        check("rst_pos_valid", int'(pos_valid), 0);
        check("rst_pulse_err", int'(pulse_err), 0);
        check("rst_lost", int'(lost), 0);
        check("rst_state", int'(dbg_state), 0);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_state_wait_rise", int'(dbg_state), 1);

        // nominal mid-scale pulse
        run_pulse(356, 400, nv, ve, vc, ee, lon, loff);
        check("mid_nvalid", nv, 1);
        check("mid_latency", ve, 4);
        check("mid_code", vc, 128);
        check("mid_err", int'(pulse_err), 0);

        // widths at and below the offset
        run_pulse(OFF, 400, nv, ve, vc, ee, lon, loff);
        check("off_nvalid", nv, 1);
        check("off_code", vc, 0);
        run_pulse(50, 400, nv, ve, vc, ee, lon, loff);
        check("short_nvalid", nv, 1);
        check("short_code", vc, 0);

        // saturation, then single-LSB steps
        run_pulse(650, 400, nv, ve, vc, ee, lon, loff);
        check("sat_code", vc, 255);
        run_pulse(102, 400, nv, ve, vc, ee, lon, loff);
        check("one_lsb_code", vc, 1);
        run_pulse(101, 400, nv, ve, vc, ee, lon, loff);
        check("below_lsb_code", vc, 0);
        run_pulse(MAXP, 400, nv, ve, vc, ee, lon, loff);
        check("maxw_nvalid", nv, 1);
        check("maxw_code", vc, 255);
        check("maxw_err", ee, 0);

        // overlong pulse: error at high clock MAX+1, pos_out keeps 255
        run_pulse(800, 400, nv, ve, vc, ee, lon, loff);
        check("err_nvalid", nv, 0);
        check("err_edge", ee, MAXP + 3);
        check("err_sticky", int'(pulse_err), 1);
        check("err_pos_hold", int'(pos_out), 255);
        run_pulse(356, 400, nv, ve, vc, ee, lon, loff);
        check("after_err_code", vc, 128);
        check("after_err_clear", int'(pulse_err), 0);

        // timeout: lost sets TIMEOUT edges after the rise seen at edge 3
        run_pulse(356, 3100, nv, ve, vc, ee, lon, loff);
        check("to_code", vc, 128);
        check("to_lost_edge", lon, TOUT + 3);
        check("to_pos_hold", int'(pos_out), 128);
        check("to_state_kept", int'(dbg_state), 1);
        run_pulse(356, 400, nv, ve, vc, ee, lon, loff);
        check("lost_clear_edge", loff, 3);
        check("lost_clear_nvalid", nv, 1);
        check("lost_clear_code", vc, 128);

        // a rise that lands on the terminal count keeps lost low
        run_pulse(356, TOUT - 356, nv, ve, vc, ee, lon, loff);
        check("tc_first_lost", lon, 0);
        run_pulse(356, 400, nv, ve, vc, ee, lon, loff);
        check("tc_rise_wins", lon, 0);

        // enable low: no decode, outputs hold
        run_pulse(102, 400, nv, ve, vc, ee, lon, loff);
        check("pre_ena_code", vc, 1);
        ena = 1'b0;
        run_pulse(356, 400, nv, ve, vc, ee, lon, loff);
        check("dis_nvalid", nv, 0);
        check("dis_pos_hold", int'(pos_out), 1);
        check("dis_state", int'(dbg_state), 0);
        ena = 1'b1;
        run_pulse(356, 400, nv, ve, vc, ee, lon, loff);
        check("reena_code", vc, 128);

        // reset in the middle of a pulse
        nv     = 0;
        pwm_in = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pos_out", int'(pos_out), 0);
        check("midrst_state", int'(dbg_state), 0);
        check("midrst_lost", int'(lost), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 0; e < 550; e++) begin
            @(posedge clk);
            #1;
            if (e == 150) pwm_in = 1'b0;
            if (pos_valid) nv++;
        end
        check("midrst_nvalid", nv, 0);
        run_pulse(356, 400, nv, ve, vc, ee, lon, loff);
        check("midrst_next_nvalid", nv, 1);
        check("midrst_next_code", vc, 128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // hard time limit, in case something stalls
    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
